pcd_miller_encoder: RTL and testbench

PCD_MILLER_ENCODER -- requirements
Module: pcd_miller_encoder

---
 rtl/ISO14443A_pkg.sv | 37 +++
 rtl/pcd_miller_encoder_pause.sv | 54 +++++
 rtl/pcd_miller_encoder.sv | 184 ++++++++++++++++++
 tb/tb_pcd_miller_encoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ISO14443A_pkg.sv
// ISO 14443-A PCD shared types: modified-Miller bit sequences, timing constants,
// encoder FSM states and the sequence-selection helper.
package ISO14443A_pkg;

  typedef enum logic [1:0] {
    PCDBitSequence_ERROR = 2'd0,
    PCDBitSequence_X     = 2'd1,
    PCDBitSequence_Y     = 2'd2,
    PCDBitSequence_Z     = 2'd3
  } PCDBitSequence;

  localparam int unsigned PCD_BIT_CYCLES   = 128;
  localparam int unsigned PCD_PAUSE_CYCLES = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSoc,
    StData,
    StParity,
    StEocZero,
    StEocY
  } pcd_state_e;

  // A 0 following a 1 must be Y so that X is never followed by Z.
  function automatic PCDBitSequence miller_encode(input logic bit_val, input logic prev_zero);
    PCDBitSequence s;
    if (bit_val) begin
      s = PCDBitSequence_X;
    end else if (prev_zero) begin
      s = PCDBitSequence_Z;
    end else begin
      s = PCDBitSequence_Y;
    end
    return s;
  endfunction

endpackage

// File: rtl/pcd_miller_encoder_pause.sv
// Bit-time counter and carrier pause shaping for the current Miller sequence.
module pcd_pause_generator
  import ISO14443A_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = PCD_BIT_CYCLES,
  parameter int unsigned PAUSE_CYCLES = PCD_PAUSE_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  PCDBitSequence                 seq,
  input  logic                          seq_strobe,
  output logic                          pause_n,
  output logic [$clog2(BIT_CYCLES)-1:0] bit_cnt
);

  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam logic [CntW-1:0] LastCnt   = CntW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] PauseEnd  = CntW'(PAUSE_CYCLES);
  localparam logic [CntW-1:0] HalfStart = CntW'(BIT_CYCLES / 2);
  localparam logic [CntW-1:0] HalfEnd   = CntW'(BIT_CYCLES / 2 + PAUSE_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The strobe cycle is count 0; the counter then runs to the wrap and rests at 0
  // unless another bit time is strobed.
  always_comb begin
    cnt_d = '0;
    if (cnt_q == LastCnt) begin
      cnt_d = '0;
    end else if (cnt_q != '0 || seq_strobe) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pause_n = 1'b1;
    case (seq)
      PCDBitSequence_Z: pause_n = !(cnt_q < PauseEnd);
      PCDBitSequence_X: pause_n = !((cnt_q >= HalfStart) && (cnt_q < HalfEnd));
      default:          pause_n = 1'b1;
    endcase
  end

  assign bit_cnt = cnt_q;

endmodule

// File: rtl/pcd_miller_encoder.sv
// PCD modified-Miller framer: SOC, LSb-first data with odd parity per full byte,
// EOC, fed from a one-byte holding register.
module pcd_miller_encoder
  import ISO14443A_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = PCD_BIT_CYCLES,
  parameter int unsigned PAUSE_CYCLES = PCD_PAUSE_CYCLES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [2:0]    in_bits,
  input  logic          in_last,
  output logic          pause_n,
  output PCDBitSequence seq,
  output logic          seq_strobe,
  output logic          busy,
  output logic          underrun
);

  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);

  pcd_state_e    state_q, state_d;
  PCDBitSequence seq_q, seq_d;
  logic          strobe_q, strobe_d;
  logic          prev_zero_q, prev_zero_d;
  logic          underrun_q, underrun_d;
  logic          hold_full_q, hold_last_q, last_seen_q;
  logic [7:0]    hold_data_q, byte_q;
  logic [2:0]    hold_bits_q;
  logic [6:0]    shift_q;
  logic [3:0]    bits_left_q;
  logic          full8_q, cur_last_q;
  logic [CntW-1:0] bit_cnt;
  logic          accept, bit_end, load, new_bit;

  assign accept  = in_valid && in_ready;
  assign bit_end = (bit_cnt == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      StIdle: if (hold_full_q || accept) state_d = StSoc;
      StSoc: begin
        if (bit_end) begin
          state_d = StData;
          load    = 1'b1;
        end
      end
      StData: begin
        if (bit_end && bits_left_q == 4'd1) state_d = full8_q ? StParity : StEocZero;
      end
      StParity: begin
        if (bit_end) begin
          if (cur_last_q) begin
            state_d = StEocZero;
          end else if (hold_full_q) begin
            state_d = StData;
            load    = 1'b1;
          end else begin
            state_d    = StIdle;
            underrun_d = 1'b1;
          end
        end
      end
      StEocZero: if (bit_end) state_d = StEocY;
      StEocY:    if (bit_end) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Sequence for the bit time that starts on the next cycle.
  always_comb begin
    seq_d       = seq_q;
    strobe_d    = 1'b0;
    prev_zero_d = prev_zero_q;
    new_bit     = (state_q == StIdle) ? (state_d == StSoc) : bit_end;
    if (state_d == StIdle) begin
      seq_d = PCDBitSequence_Y;
    end else if (new_bit) begin
      strobe_d = 1'b1;
      case (state_d)
        StSoc: begin
          seq_d       = PCDBitSequence_Z;
          prev_zero_d = 1'b1;
        end
        StData: begin
          seq_d       = miller_encode(load ? hold_data_q[0] : shift_q[0], prev_zero_q);
          prev_zero_d = !(load ? hold_data_q[0] : shift_q[0]);
        end
        StParity: begin
          seq_d       = miller_encode(~^byte_q, prev_zero_q);
          prev_zero_d = ^byte_q;
        end
        StEocZero: begin
          seq_d       = miller_encode(1'b0, prev_zero_q);
          prev_zero_d = 1'b1;
        end
        default: seq_d = PCDBitSequence_Y;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q       <= PCDBitSequence_Y;
      strobe_q    <= 1'b0;
      prev_zero_q <= 1'b1;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      hold_data_q <= '0;
      hold_bits_q <= '0;
      last_seen_q <= 1'b0;
      byte_q      <= '0;
      shift_q     <= '0;
      bits_left_q <= '0;
      full8_q     <= 1'b0;
      cur_last_q  <= 1'b0;
    end else begin
      seq_q       <= seq_d;
      strobe_q    <= strobe_d;
      prev_zero_q <= prev_zero_d;
      underrun_q  <= underrun_d;
      if (load) hold_full_q <= 1'b0;
      if (accept) begin
        hold_full_q <= 1'b1;
        hold_data_q <= in_data;
        hold_bits_q <= in_bits;
        hold_last_q <= in_last;
      end
      if (accept && in_last) begin
        last_seen_q <= 1'b1;
      end else if (state_q != StIdle && state_d == StIdle) begin
        last_seen_q <= 1'b0;
      end
      if (load) begin
        byte_q      <= hold_data_q;
        shift_q     <= hold_data_q[7:1];
        bits_left_q <= (hold_last_q && hold_bits_q != 3'd0) ? {1'b0, hold_bits_q} : 4'd8;
        full8_q     <= !(hold_last_q && hold_bits_q != 3'd0);
        cur_last_q  <= hold_last_q;
      end else if (state_q == StData && bit_end) begin
        shift_q     <= shift_q >> 1;
        bits_left_q <= bits_left_q - 4'd1;
      end
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    in_ready = !hold_full_q && !last_seen_q;
  end

  assign seq        = seq_q;
  assign seq_strobe = strobe_q;
  assign underrun   = underrun_q;

  pcd_pause_generator #(
    .BIT_CYCLES  (BIT_CYCLES),
    .PAUSE_CYCLES(PAUSE_CYCLES)
  ) u_pause (
    .clk       (clk),
    .rst_n     (rst_n),
    .seq       (seq_q),
    .seq_strobe(strobe_q),
    .pause_n   (pause_n),
    .bit_cnt   (bit_cnt)
  );

endmodule

// File: tb/tb_pcd_miller_encoder.sv
// Directed bench for pcd_miller_encoder: REQA, HLTA, pause timing, underrun,
// mid-frame reset and back-to-back frames.
module tb_pcd_miller_encoder;
  import ISO14443A_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic [2:0]    in_bits = 3'd0;
  logic          in_ready, pause_n, seq_strobe, busy, underrun;
  PCDBitSequence seq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcd_miller_encoder #(
    .BIT_CYCLES  (128),
    .PAUSE_CYCLES(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bits   (in_bits),
    .in_last   (in_last),
    .pause_n   (pause_n),
    .seq       (seq),
    .seq_strobe(seq_strobe),
    .busy      (busy),
    .underrun  (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic PCDBitSequence ch2seq(input byte c);
    PCDBitSequence s;
    case (c)
      "X":     s = PCDBitSequence_X;
      "Y":     s = PCDBitSequence_Y;
      "Z":     s = PCDBitSequence_Z;
      default: s = PCDBitSequence_ERROR;
    endcase
    return s;
  endfunction

  // Z pauses on cycles 0..31, X on 64..95, Y never.
  function automatic logic exp_pause(input PCDBitSequence e, input int k);
    if (e == PCDBitSequence_Z) return !(k < 32);
    if (e == PCDBitSequence_X) return !(k >= 64 && k < 96);
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] d, input logic [2:0] nb, input logic last);
    int ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_bits  = nb;
    in_last  = last;
    for (int i = 0; i < 10000; i++) begin
      if (in_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk($sformatf("accept %02h", d), 32'(ok), 32'd1);
  endtask

  // Follows one frame bit time by bit time; ends on the first cycle after it.
  task automatic watch_frame(input string tag, input string s);
    int t;
    int bad;
    PCDBitSequence e;
    t = 0;
    while (!seq_strobe && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " start"}, 32'(seq_strobe), 32'd1);
    for (int b = 0; b < s.len(); b++) begin
      e = ch2seq(s[b]);
      chk($sformatf("%s bit%0d seq", tag, b), 32'(seq), 32'(e));
      bad = 0;
      for (int k = 0; k < 128; k++) begin
        if (pause_n !== exp_pause(e, k) || seq !== e || busy !== 1'b1 ||
            underrun !== 1'b0 || seq_strobe !== (k == 0)) bad++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d timing", tag, b), 32'(bad), 32'd0);
    end
    chk({tag, " end busy"}, 32'(busy), 32'd0);
    chk({tag, " end pause_n"}, 32'(pause_n), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst pause_n", 32'(pause_n), 32'd1);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst seq_strobe", 32'(seq_strobe), 32'd0);
    chk("rst underrun", 32'(underrun), 32'd0);
    chk("rst seq", 32'(seq), 32'(PCDBitSequence_Y));
    rst_n = 1'b1;
    @(negedge clk);

    // REQA: 7 bits, no parity, 10 bit times.
    fork
      send_byte(8'h26, 3'd7, 1'b1);
      watch_frame("reqa", "ZZXXYZXYZY");
    join
    chk("reqa underrun", 32'(underrun), 32'd0);
    chk("reqa in_ready idle", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);

    // HLTA followed by a REQA accepted on the first IDLE cycle.
    fork
      begin
        send_byte(8'h50, 3'd0, 1'b0);
        send_byte(8'h00, 3'd0, 1'b1);
        send_byte(8'h26, 3'd7, 1'b1);
      end
      begin
        watch_frame("hlta", "ZZZZZXYXYXYZZZZZZZXYY");
        chk("b2b idle ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("b2b soc strobe", 32'(seq_strobe), 32'd1);
        chk("b2b soc seq", 32'(seq), 32'(PCDBitSequence_Z));
        watch_frame("b2b", "ZZXXYZXYZY");
      end
    join
    repeat (3) @(negedge clk);

    // Underrun: second byte never offered.
    fork
      send_byte(8'h01, 3'd0, 1'b0);
      watch_frame("urun", "ZXYZZZZZZZ");
    join
    chk("urun pulse", 32'(underrun), 32'd1);
    chk("urun seq", 32'(seq), 32'(PCDBitSequence_Y));
    @(negedge clk);
    chk("urun pulse end", 32'(underrun), 32'd0);
    chk("urun ready", 32'(in_ready), 32'd1);
    chk("urun busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // Reset asserted during the SOC pause.
    fork
      send_byte(8'h26, 3'd7, 1'b1);
      begin
        for (int i = 0; i < 400 && !seq_strobe; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("mid pause low", 32'(pause_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid rst pause_n", 32'(pause_n), 32'd1);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst in_ready", 32'(in_ready), 32'd1);
        chk("mid rst seq", 32'(seq), 32'(PCDBitSequence_Y));
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    @(negedge clk);
    chk("post rst pause_n", 32'(pause_n), 32'd1);
    chk("post rst busy", 32'(busy), 32'd0);
    fork
      send_byte(8'h26, 3'd7, 1'b1);
      watch_frame("post rst", "ZZXXYZXYZY");
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
